// File: rtl/rv_wb_pkg.sv
// Writeback-select and load-type encodings shared by the WB stage and ID/control decode.
package rv_wb_pkg;

  localparam logic [1:0] WBSEL_ALU  = 2'b00;
  localparam logic [1:0] WBSEL_LOAD = 2'b01;
  localparam logic [1:0] WBSEL_PC4  = 2'b10;
  localparam logic [1:0] WBSEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Extracts a byte/half/word from an aligned load word and sign- or zero-extends it.
module load_extend
  import rv_wb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3_i,
  input  logic [1:0]   addr_lo_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] ext_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = data_i[{addr_lo_i, 3'b000} +: 8];
  // Halfword lanes are selected by addr[1] only; addr[0] is ignored.
  assign half_v = data_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    ext_o = data_i;
    case (funct3_i)
      F3_LB:   ext_o = {{(N-8){byte_v[7]}}, byte_v};
      F3_LH:   ext_o = {{(N-16){half_v[15]}}, half_v};
      F3_LBU:  ext_o = {{(N-8){1'b0}}, byte_v};
      F3_LHU:  ext_o = {{(N-16){1'b0}}, half_v};
      default: ext_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback result mux, register-file write port and instret.
module wb_stage
  import rv_wb_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wbsel,
  input  logic [2:0]       mem_funct3,
  input  logic [1:0]       mem_addr_lo,
  input  logic [N-1:0]     mem_alu_result,
  input  logic [N-1:0]     mem_load_data,
  input  logic [N-1:0]     mem_pc_plus4,
  input  logic [N-1:0]     mem_imm,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             regwrite,
  output logic [4:0]       writereg,
  output logic [N-1:0]     writedata,
  output logic             fwd_en,
  output logic [4:0]       fwd_rd,
  output logic [N-1:0]     fwd_data,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             regwrite_q;
  logic [4:0]       rd_q;
  logic [1:0]       wbsel_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [N-1:0]     alu_q, load_q, pc4_q, imm_q;
  logic             capture;
  logic [N-1:0]     load_ext;
  logic [N-1:0]     sel_data;

  assign capture = !wb_flush && !wb_stall;

  always_comb begin
    valid_d   = valid_q;
    instret_d = instret_q;
    if (wb_flush)       valid_d = 1'b0;
    else if (!wb_stall) valid_d = mem_valid;
    // The departing instruction retires even when a flush lands in the same cycle.
    if (valid_q && !wb_stall) instret_d = instret_q + 1'b1;
  end

  // MEM -> WB boundary: control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instret_q <= instret_d;
    end
  end

  // MEM -> WB boundary: datapath fields, observable only through valid_q gating
  always_ff @(posedge clk) begin
    if (capture) begin
      regwrite_q <= mem_regwrite;
      rd_q       <= mem_rd;
      wbsel_q    <= mem_wbsel;
      funct3_q   <= mem_funct3;
      addr_lo_q  <= mem_addr_lo;
      alu_q      <= mem_alu_result;
      load_q     <= mem_load_data;
      pc4_q      <= mem_pc_plus4;
      imm_q      <= mem_imm;
    end
  end

  load_extend #(.N(N)) u_load_extend (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .data_i    (load_q),
    .ext_o     (load_ext)
  );

  always_comb begin
    sel_data = alu_q;
    case (wbsel_q)
      WBSEL_LOAD: sel_data = load_ext;
      WBSEL_PC4:  sel_data = pc4_q;
      WBSEL_IMM:  sel_data = imm_q;
      default:    sel_data = alu_q;
    endcase
  end

  assign regwrite  = valid_q && regwrite_q && (rd_q != 5'd0);
  assign writereg  = valid_q ? rd_q : 5'd0;
  assign writedata = valid_q ? sel_data : '0;
  assign fwd_en    = regwrite;
  assign fwd_rd    = writereg;
  assign fwd_data  = writedata;
  assign wb_valid  = valid_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second CNT_W=4 instance shares the inputs for the wrap check.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm;
  logic        wb_stall, wb_flush;

  logic        regwrite, fwd_en, wb_valid;
  logic [4:0]  writereg, fwd_rd;
  logic [31:0] writedata, fwd_data;
  logic [63:0] instret;

  logic        s_regwrite, s_fwd_en, s_wb_valid;
  logic [4:0]  s_writereg, s_fwd_rd;
  logic [31:0] s_writedata, s_fwd_data;
  logic [3:0]  s_instret;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage #(.N(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .regwrite(regwrite),
    .writereg(writereg), .writedata(writedata), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .wb_valid(wb_valid), .instret(instret)
  );

  wb_stage #(.N(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .regwrite(s_regwrite),
    .writereg(s_writereg), .writedata(s_writedata), .fwd_en(s_fwd_en),
    .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .wb_valid(s_wb_valid),
    .instret(s_instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] al, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc4,
                         input logic [31:0] imm);
    mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wbsel = sel;
    mem_funct3 = f3; mem_addr_lo = al; mem_alu_result = alu;
    mem_load_data = ld; mem_pc_plus4 = pc4; mem_imm = imm;
  endtask

  task automatic do_reset();
    wb_stall = 1'b0; wb_flush = 1'b0;
    set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", wb_valid); end
    n_tests++; if (regwrite !== 1'b0 || writereg !== 5'd0 || writedata !== 32'h0)
      begin n_fail++; $display("FAIL reset_wport got %0h/%0h/%0h want 0/0/0", regwrite, writereg, writedata); end
    n_tests++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", instret); end
    set_mem(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'b00, 32'hDEAD, 32'h0, 32'h0, 32'h0);
    step();
    step();
    n_tests++; if (regwrite !== 1'b1 || writedata !== 32'hDEAD || instret !== 64'd1)
      begin n_fail++; $display("FAIL pre_rst got rw=%0h wd=%0h cnt=%0d want 1/dead/1", regwrite, writedata, instret); end
    rst = 1'b1;
    #1;
    n_tests++; if (regwrite !== 1'b0 || writedata !== 32'h0 || instret !== 64'd0 || wb_valid !== 1'b0)
      begin n_fail++; $display("FAIL async_rst got rw=%0h wd=%0h cnt=%0d v=%0h want 0/0/0/0", regwrite, writedata, instret, wb_valid); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]  adrs [5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_8080, 32'h0000_F0F0, 32'h8080_F0F0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_mem(1'b1, 1'b1, 5'd3, 2'b01, f3s[i], adrs[i], 32'h0, 32'h8080_F0F0, 32'h0, 32'h0);
      step();
      n_tests++; if (writedata !== exps[i] || writereg !== 5'd3)
        begin n_fail++; $display("FAIL load_ext[%0d] got %08h rd=%0d want %08h rd=3", i, writedata, writereg, exps[i]); end
    end
  endtask

  task automatic test_x0_guard();
    do_reset();
    set_mem(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 2'b00, 32'h1234, 32'h0, 32'h0, 32'h0);
    step();
    n_tests++; if (regwrite !== 1'b0 || fwd_en !== 1'b0 || wb_valid !== 1'b1)
      begin n_fail++; $display("FAIL x0_guard got rw=%0h fe=%0h v=%0h want 0/0/1", regwrite, fwd_en, wb_valid); end
    n_tests++; if (writedata !== 32'h1234) begin n_fail++; $display("FAIL x0_data got %08h want 00001234", writedata); end
    mem_valid = 1'b0;
    step();
    n_tests++; if (instret !== 64'd1) begin n_fail++; $display("FAIL x0_instret got %0d want 1", instret); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    set_mem(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 2'b00, 32'h55AA, 32'h0, 32'h0, 32'h0);
    step();
    set_mem(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 2'b00, 32'h1111, 32'h0, 32'h0, 32'h0);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (regwrite !== 1'b1 || writereg !== 5'd7 || writedata !== 32'h55AA || instret !== 64'd0)
        begin n_fail++; $display("FAIL stall[%0d] got rw=%0h rd=%0d wd=%08h cnt=%0d want 1/7/000055aa/0", i, regwrite, writereg, writedata, instret); end
    end
    wb_flush = 1'b1;
    step();
    n_tests++; if (wb_valid !== 1'b0 || regwrite !== 1'b0 || writedata !== 32'h0 || instret !== 64'd0)
      begin n_fail++; $display("FAIL flush_stall got v=%0h rw=%0h wd=%08h cnt=%0d want 0/0/0/0", wb_valid, regwrite, writedata, instret); end
    wb_flush = 1'b0; wb_stall = 1'b0;
    step();
    wb_flush = 1'b1;
    step();
    n_tests++; if (wb_valid !== 1'b0 || instret !== 64'd1)
      begin n_fail++; $display("FAIL flush_retire got v=%0h cnt=%0d want 0/1", wb_valid, instret); end
    wb_flush = 1'b0;
  endtask

  task automatic test_select();
    do_reset();
    set_mem(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 2'b00, 32'hBAD0, 32'hBAD1, 32'h100, 32'hBAD2);
    step();
    n_tests++; if (writedata !== 32'h100 || fwd_data !== 32'h100 || fwd_rd !== 5'd1 || fwd_en !== 1'b1)
      begin n_fail++; $display("FAIL sel_pc4 got wd=%08h fd=%08h frd=%0d fe=%0h want 100/100/1/1", writedata, fwd_data, fwd_rd, fwd_en); end
    set_mem(1'b1, 1'b1, 5'd2, 2'b11, 3'b000, 2'b00, 32'hBAD0, 32'hBAD1, 32'h100, 32'hABCD_E000);
    step();
    n_tests++; if (writedata !== 32'hABCD_E000 || writereg !== 5'd2)
      begin n_fail++; $display("FAIL sel_imm got %08h rd=%0d want abcde000 rd=2", writedata, writereg); end
    mem_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed;
    logic [4:0]  er;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ed = 32'h1000 + 32'(i * 3);
      er = 5'(i + 1);
      set_mem(1'b1, 1'b1, er, 2'b00, 3'b000, 2'b00, ed, 32'h0, 32'h0, 32'h0);
      step();
      n_tests++; if (writedata !== ed || writereg !== er || regwrite !== 1'b1)
        begin n_fail++; $display("FAIL b2b[%0d] got %08h rd=%0d rw=%0h want %08h rd=%0d rw=1", i, writedata, writereg, regwrite, ed, er); end
      n_tests++; if ({s_regwrite, s_writereg, s_writedata, s_fwd_en, s_fwd_rd, s_fwd_data, s_wb_valid} !==
                     {1'b1, er, ed, 1'b1, er, ed, 1'b1})
        begin n_fail++; $display("FAIL b2b_small[%0d] got wd=%08h rd=%0d want %08h rd=%0d", i, s_writedata, s_writereg, ed, er); end
    end
    mem_valid = 1'b0;
    step();
    n_tests++; if (s_instret !== 4'd1) begin n_fail++; $display("FAIL wrap got %0d want 1", s_instret); end
    n_tests++; if (instret !== 64'd17) begin n_fail++; $display("FAIL count17 got %0d want 17", instret); end
  endtask

  initial begin
    rst = 1'b1;
    wb_stall = 1'b0; wb_flush = 1'b0;
    set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    test_reset();
    test_load_extend();
    test_x0_guard();
    test_stall_flush();
    test_select();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
